microcode_sequencer: RTL and testbench

Instruction-level controller that drives the 9-bit opcode index into the microcode ROM and sequences its 65-bit control words over time. It fetches opcode bytes, folds the 0xCB prefix into bit 8, and steps a micro-op counter until the control word signals end-of-instruction. It stalls on memory waits, dispatches interrupts via a pseudo-opcode, and implements HALT. It sits between the memory interface, the microcode ROM and the CPU datapath.

---
 rtl/microcode_sequencer_if.sv | 69 ++++++
 rtl/microcode_sequencer.sv | 171 +++++++++++++++++
 tb/tb_microcode_sequencer.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/microcode_sequencer_if.sv
// Bus bundle between the microcode sequencer and its neighbours: the memory
// port, the microcode ROM index, control-word fields fed back from the ROM,
// interrupt handshake and status flags.
interface microcode_sequencer_if #(
  parameter int STEP_W = 3
);

  // Memory interface
  logic              mem_req;
  logic              mem_ready;
  logic [7:0]        mem_rdata;
  logic              pc_inc;

  // Microcode ROM addressing and datapath strobe
  logic [8:0]        ucode_addr;
  logic [STEP_W-1:0] ucode_step;
  logic              uop_valid;

  // Control-word fields read back from the ROM output
  logic              ctrl_last;
  logic              ctrl_mem;
  logic              ctrl_halt;

  // Interrupt handshake and status
  logic              irq_pending;
  logic              ime;
  logic              irq_ack;
  logic              halted;
  logic              ucode_err;

  // Sequencer side
  modport master (
    output mem_req,
    output pc_inc,
    output ucode_addr,
    output ucode_step,
    output uop_valid,
    output irq_ack,
    output halted,
    output ucode_err,
    input  mem_ready,
    input  mem_rdata,
    input  ctrl_last,
    input  ctrl_mem,
    input  ctrl_halt,
    input  irq_pending,
    input  ime
  );

  // Environment side: memory, ROM and interrupt controller
  modport slave (
    input  mem_req,
    input  pc_inc,
    input  ucode_addr,
    input  ucode_step,
    input  uop_valid,
    input  irq_ack,
    input  halted,
    input  ucode_err,
    output mem_ready,
    output mem_rdata,
    output ctrl_last,
    output ctrl_mem,
    output ctrl_halt,
    output irq_pending,
    output ime
  );

endinterface

// File: rtl/microcode_sequencer.sv
// Instruction-level controller. Fetches opcode bytes (folding the CB prefix
// into index bit 8), presents {opcode, step} to the microcode ROM and steps
// the micro-op counter until the control word ends the instruction. Memory
// waits stall the current micro-op; interrupts are dispatched by loading a
// pseudo-opcode at an instruction boundary; HALT idles until an interrupt.
module microcode_sequencer #(
  parameter int         STEP_W     = 3,
  parameter int         MAX_STEPS  = 6,
  parameter logic [8:0] IRQ_OPCODE = 9'h1D8,
  parameter logic [7:0] CB_PREFIX  = 8'hCB
) (
  input  logic                   clk,
  input  logic                   rst,
  microcode_sequencer_if.master  bus
);

  typedef enum logic [1:0] {
    S_FETCH,
    S_FETCH_CB,
    S_EXEC,
    S_HALT
  } state_e;

  // Last step index an instruction may occupy before it is cut short.
  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(MAX_STEPS - 1);

  state_e            state_q, state_d;
  logic [8:0]        opcode_q, opcode_d;
  logic [STEP_W-1:0] step_q, step_d;
  logic              err_q, err_d;

  // Raw combinational strobes; gated with rst before leaving the block.
  logic              mem_req_c;
  logic              pc_inc_c;
  logic              uop_valid_c;
  logic              irq_ack_c;
  logic              halted_c;

  // Instruction-boundary qualifiers, meaningful only in S_EXEC.
  logic              uop_stalled;
  logic              step_overflow;
  logic              instr_end;
  logic              irq_take;

  // A memory-accessing micro-op cannot retire until memory answers.
  assign uop_stalled   = bus.ctrl_mem && !bus.mem_ready;
  assign step_overflow = (step_q == LAST_STEP);
  assign irq_take      = bus.irq_pending && bus.ime;

  // State, opcode, step and sticky error registers.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values computed by the combinational block.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_FETCH;
      opcode_q <= 9'h000;
      step_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      opcode_q <= opcode_d;
      step_q   <= step_d;
      err_q    <= err_d;
    end
  end

  // Next-state and strobe decode for fetch, execute, stall and halt.
  // NOTE: every variable gets a default first so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d     = state_q;
    opcode_d    = opcode_q;
    step_d      = step_q;
    err_d       = err_q;
    mem_req_c   = 1'b0;
    pc_inc_c    = 1'b0;
    uop_valid_c = 1'b0;
    irq_ack_c   = 1'b0;
    halted_c    = 1'b0;
    instr_end   = 1'b0;

    case (state_q)
      // Opcode byte fetch; a CB byte only selects the extended page.
      S_FETCH: begin
        mem_req_c = 1'b1;
        pc_inc_c  = bus.mem_ready;
        if (bus.mem_ready) begin
          if (bus.mem_rdata == CB_PREFIX) begin
            state_d = S_FETCH_CB;
          end else begin
            opcode_d = {1'b0, bus.mem_rdata};
            step_d   = '0;
            state_d  = S_EXEC;
          end
        end
      end

      // Second byte after the prefix; taken literally, even if it is CB.
      S_FETCH_CB: begin
        mem_req_c = 1'b1;
        pc_inc_c  = bus.mem_ready;
        if (bus.mem_ready) begin
          opcode_d = {1'b1, bus.mem_rdata};
          step_d   = '0;
          state_d  = S_EXEC;
        end
      end

      // Micro-op execution. The control word for {opcode, step} is on the
      // ctrl_* inputs; a stall freezes both opcode and step.
      S_EXEC: begin
        mem_req_c   = bus.ctrl_mem;
        uop_valid_c = !uop_stalled;
        instr_end   = uop_valid_c && (bus.ctrl_last || step_overflow);
        if (instr_end) begin
          // Running off the end without ctrl_last means a broken
          // microprogram; flag it but still move on.
          if (!bus.ctrl_last) begin
            err_d = 1'b1;
          end
          step_d = '0;
          if (bus.ctrl_halt) begin
            state_d = S_HALT;
          end else if (irq_take) begin
            opcode_d  = IRQ_OPCODE;
            irq_ack_c = 1'b1;
            state_d   = S_EXEC;
          end else begin
            state_d = S_FETCH;
          end
        end else if (uop_valid_c) begin
          step_d = step_q + STEP_W'(1);
        end
      end

      // Idle until any interrupt is flagged; dispatch only if enabled.
      S_HALT: begin
        halted_c = 1'b1;
        if (bus.irq_pending) begin
          if (bus.ime) begin
            opcode_d  = IRQ_OPCODE;
            step_d    = '0;
            irq_ack_c = 1'b1;
            state_d   = S_EXEC;
          end else begin
            state_d = S_FETCH;
          end
        end
      end

      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

  // Strobes are forced low for as long as reset is held, so the bus is
  // quiet immediately rather than showing the FETCH request.
  assign bus.mem_req    = mem_req_c   & ~rst;
  assign bus.pc_inc     = pc_inc_c    & ~rst;
  assign bus.uop_valid  = uop_valid_c & ~rst;
  assign bus.irq_ack    = irq_ack_c   & ~rst;
  assign bus.halted     = halted_c    & ~rst;

  // ROM index and status come straight from registers, so they hold
  // steady through stalls and clear asynchronously with reset.
  assign bus.ucode_addr = opcode_q;
  assign bus.ucode_step = step_q;
  assign bus.ucode_err  = err_q;

endmodule

// File: tb/tb_microcode_sequencer.sv
// Self-checking bench for microcode_sequencer: a vector table for the basic
// fetch/execute rhythm, directed sequences for stalls, interrupts, HALT,
// step overflow and mid-instruction reset, then randomized traffic against
// an instruction-level reference model.
module tb_microcode_sequencer;

  localparam int         STEP_W    = 3;
  localparam int         MAX_STEPS = 6;
  localparam logic [8:0] IRQ_OP    = 9'h1D8;
  localparam logic [7:0] CB        = 8'hCB;

  logic clk = 1'b0;
  logic rst;

  microcode_sequencer_if #(.STEP_W(STEP_W)) bus ();

  microcode_sequencer #(
    .STEP_W     (STEP_W),
    .MAX_STEPS  (MAX_STEPS),
    .IRQ_OPCODE (IRQ_OP),
    .CB_PREFIX  (CB)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic req, input logic inc,
                           input logic uop, input logic [8:0] addr,
                           input logic [2:0] step, input logic ack,
                           input logic hlt, input logic err);
    check({tag, ".mem_req"},    32'(bus.mem_req),    32'(req));
    check({tag, ".pc_inc"},     32'(bus.pc_inc),     32'(inc));
    check({tag, ".uop_valid"},  32'(bus.uop_valid),  32'(uop));
    check({tag, ".ucode_addr"}, 32'(bus.ucode_addr), 32'(addr));
    check({tag, ".ucode_step"}, 32'(bus.ucode_step), 32'(step));
    check({tag, ".irq_ack"},    32'(bus.irq_ack),    32'(ack));
    check({tag, ".halted"},     32'(bus.halted),     32'(hlt));
    check({tag, ".ucode_err"},  32'(bus.ucode_err),  32'(err));
  endtask

  // Apply one cycle of inputs at the falling edge, settle, return for checks.
  task automatic drive(input logic rdy, input logic [7:0] rdata,
                       input logic last, input logic mem, input logic hlt,
                       input logic irq, input logic ie);
    @(negedge clk);
    bus.mem_ready   = rdy;
    bus.mem_rdata   = rdata;
    bus.ctrl_last   = last;
    bus.ctrl_mem    = mem;
    bus.ctrl_halt   = hlt;
    bus.irq_pending = irq;
    bus.ime         = ie;
    #1;
  endtask

  // ---------------- Reference model (instruction level) ----------------
  // Tracks whether an instruction is in flight, how many micro-ops of it
  // have retired, whether a prefix byte was seen, and whether the CPU is
  // halted. Expected strobes are derived from those facts each cycle.
  bit         m_busy, m_prefix, m_halt, m_err;
  int         m_uops;
  logic [8:0] m_op;
  logic       e_req, e_inc, e_uop, e_ack, e_halted, e_err;
  logic [8:0] e_addr;
  logic [2:0] e_step;
  bit         e_end;

  task automatic model_reset();
    m_busy = 0; m_prefix = 0; m_halt = 0; m_err = 0;
    m_uops = 0; m_op = 9'h000;
  endtask

  task automatic model_eval();
    e_req = 0; e_inc = 0; e_uop = 0; e_ack = 0; e_halted = 0; e_end = 0;
    e_addr = m_op; e_step = 3'(m_uops); e_err = m_err;
    if (rst) begin
      e_addr = 9'h000; e_step = 3'd0; e_err = 1'b0;
    end else if (m_halt) begin
      e_halted = 1;
      e_ack    = bus.irq_pending && bus.ime;
    end else if (!m_busy) begin
      e_req = 1;
      e_inc = bus.mem_ready;
    end else begin
      e_req = bus.ctrl_mem;
      e_uop = !(bus.ctrl_mem && !bus.mem_ready);
      e_end = e_uop && (bus.ctrl_last || (m_uops + 1 == MAX_STEPS));
      e_ack = e_end && !bus.ctrl_halt && bus.irq_pending && bus.ime;
    end
  endtask

  task automatic model_advance();
    if (m_halt) begin
      if (bus.irq_pending) begin
        m_halt = 0;
        if (bus.ime) begin
          m_busy = 1; m_op = IRQ_OP; m_uops = 0;
        end
      end
    end else if (!m_busy) begin
      if (bus.mem_ready) begin
        if (!m_prefix && bus.mem_rdata == CB) begin
          m_prefix = 1;
        end else begin
          m_op = {m_prefix, bus.mem_rdata};
          m_prefix = 0; m_busy = 1; m_uops = 0;
        end
      end
    end else if (e_uop) begin
      m_uops++;
      if (e_end) begin
        if (!bus.ctrl_last) m_err = 1;
        m_uops = 0;
        if (bus.ctrl_halt) begin
          m_busy = 0; m_halt = 1;
        end else if (bus.irq_pending && bus.ime) begin
          m_op = IRQ_OP;
        end else begin
          m_busy = 0;
        end
      end
    end
  endtask

  // ---------------- Vector table ----------------
  typedef struct {
    logic       rdy;
    logic [7:0] rdata;
    logic       last, mem, hlt, irq, ie;
    logic       e_req, e_inc, e_uop;
    logic [8:0] e_addr;
    logic [2:0] e_step;
    logic       e_ack, e_halted, e_err;
  } vec_t;

  vec_t vecs [9];

  initial begin
    // Alternating FETCH/EXEC on opcode 0x00 with single-uop instructions.
    vecs[0] = '{1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 9'h000, 3'd0, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 9'h000, 3'd0, 1'b0, 1'b0, 1'b0};
    vecs[2] = vecs[0];
    vecs[3] = vecs[1];
    // CB prefix, then 0x37 -> index 0x137, two micro-ops.
    vecs[4] = '{1'b1, 8'hCB, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 9'h000, 3'd0, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{1'b1, 8'h37, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 9'h000, 3'd0, 1'b0, 1'b0, 1'b0};
    vecs[6] = '{1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 9'h137, 3'd0, 1'b0, 1'b0, 1'b0};
    vecs[7] = '{1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 9'h137, 3'd1, 1'b0, 1'b0, 1'b0};
    // Back in FETCH, memory not ready: request without PC increment.
    vecs[8] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 9'h137, 3'd0, 1'b0, 1'b0, 1'b0};

    // ---------------- Reset state ----------------
    rst = 1'b1;
    bus.mem_ready = 0; bus.mem_rdata = 0; bus.ctrl_last = 0; bus.ctrl_mem = 0;
    bus.ctrl_halt = 0; bus.irq_pending = 0; bus.ime = 0;
    #1;
    check_all("reset", 0, 0, 0, 9'h000, 3'd0, 0, 0, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // ---------------- Table ----------------
    for (int i = 0; i < 9; i++) begin
      drive(vecs[i].rdy, vecs[i].rdata, vecs[i].last, vecs[i].mem,
            vecs[i].hlt, vecs[i].irq, vecs[i].ie);
      check_all($sformatf("vec%0d", i), vecs[i].e_req, vecs[i].e_inc,
                vecs[i].e_uop, vecs[i].e_addr, vecs[i].e_step,
                vecs[i].e_ack, vecs[i].e_halted, vecs[i].e_err);
    end

    // ---------------- Memory stall mid-instruction ----------------
    drive(1, 8'h12, 0, 0, 0, 0, 0);
    check("stall.fetch_req", 32'(bus.mem_req), 32'd1);
    drive(1, 8'h00, 0, 0, 0, 0, 0);
    check("stall.step0_uop", 32'(bus.uop_valid), 32'd1);
    for (int k = 0; k < 3; k++) begin
      drive(0, 8'h00, 0, 1, 0, 0, 0);
      check($sformatf("stall%0d.uop", k),  32'(bus.uop_valid),  32'd0);
      check($sformatf("stall%0d.step", k), 32'(bus.ucode_step), 32'd1);
      check($sformatf("stall%0d.req", k),  32'(bus.mem_req),    32'd1);
      check($sformatf("stall%0d.addr", k), 32'(bus.ucode_addr), 32'h012);
    end
    drive(1, 8'h00, 0, 1, 0, 0, 0);
    check("stall.release_uop",  32'(bus.uop_valid),  32'd1);
    check("stall.release_step", 32'(bus.ucode_step), 32'd1);
    drive(1, 8'h00, 1, 0, 0, 0, 0);
    check("stall.advanced_step", 32'(bus.ucode_step), 32'd2);

    // ---------------- Interrupt dispatch ----------------
    drive(1, 8'h20, 0, 0, 0, 0, 0);
    drive(1, 8'h00, 1, 0, 0, 1, 1);
    check("irq.ack", 32'(bus.irq_ack), 32'd1);
    drive(1, 8'h00, 0, 0, 0, 0, 0);
    check("irq.addr",    32'(bus.ucode_addr), 32'(IRQ_OP));
    check("irq.step",    32'(bus.ucode_step), 32'd0);
    check("irq.no_req",  32'(bus.mem_req),    32'd0);
    check("irq.ack_end", 32'(bus.irq_ack),    32'd0);
    drive(1, 8'h00, 1, 0, 0, 1, 0);
    check("irq.ime0_ack", 32'(bus.irq_ack), 32'd0);
    drive(0, 8'h00, 0, 0, 0, 0, 0);
    check("irq.ime0_fetch", 32'(bus.mem_req), 32'd1);
    check("irq.ime0_inc",   32'(bus.pc_inc),  32'd0);

    // ---------------- HALT ----------------
    drive(1, 8'h76, 0, 0, 0, 0, 0);
    drive(1, 8'h00, 1, 0, 1, 1, 1);
    check("halt.priority_ack", 32'(bus.irq_ack), 32'd0);
    drive(1, 8'h00, 0, 1, 0, 0, 0);
    check("halt.halted", 32'(bus.halted),    32'd1);
    check("halt.no_req", 32'(bus.mem_req),   32'd0);
    check("halt.no_uop", 32'(bus.uop_valid), 32'd0);
    drive(1, 8'h00, 0, 0, 0, 1, 0);
    check("halt.ime0_ack", 32'(bus.irq_ack), 32'd0);
    drive(1, 8'h76, 0, 0, 0, 0, 0);
    check("halt.ime0_fetch",  32'(bus.mem_req), 32'd1);
    check("halt.ime0_unhalt", 32'(bus.halted),  32'd0);
    drive(1, 8'h00, 1, 0, 1, 0, 0);
    drive(1, 8'h00, 0, 0, 0, 1, 1);
    check("halt.ime1_ack",    32'(bus.irq_ack), 32'd1);
    check("halt.ime1_halted", 32'(bus.halted),  32'd1);
    drive(1, 8'h00, 1, 0, 0, 0, 0);
    check("halt.dispatch_addr", 32'(bus.ucode_addr), 32'(IRQ_OP));
    check("halt.dispatch_uop",  32'(bus.uop_valid),  32'd1);
    check("halt.dispatch_hlt",  32'(bus.halted),     32'd0);

    // ---------------- Step overflow ----------------
    drive(1, 8'h01, 0, 0, 0, 0, 0);
    for (int s = 0; s < MAX_STEPS; s++) begin
      drive(1, 8'h00, 0, 0, 0, 0, 0);
      check($sformatf("ovf%0d.step", s), 32'(bus.ucode_step), 32'(s));
      check($sformatf("ovf%0d.uop", s),  32'(bus.uop_valid),  32'd1);
      check($sformatf("ovf%0d.err", s),  32'(bus.ucode_err),  32'd0);
    end
    drive(0, 8'h00, 0, 0, 0, 0, 0);
    check("ovf.err_set",   32'(bus.ucode_err),  32'd1);
    check("ovf.fetch_req", 32'(bus.mem_req),    32'd1);
    check("ovf.step_zero", 32'(bus.ucode_step), 32'd0);
    drive(1, 8'h02, 0, 0, 0, 0, 0);
    drive(1, 8'h00, 0, 0, 0, 0, 0);
    check("ovf.err_sticky", 32'(bus.ucode_err), 32'd1);

    // ---------------- Reset mid-instruction ----------------
    drive(0, 8'h00, 0, 1, 0, 1, 1);
    check("rstmid.pre_req",  32'(bus.mem_req),    32'd1);
    check("rstmid.pre_step", 32'(bus.ucode_step), 32'd1);
    rst = 1'b1;
    #1;
    check_all("rstmid", 0, 0, 0, 9'h000, 3'd0, 0, 0, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check("rstmid.refetch", 32'(bus.mem_req), 32'd1);

    // ---------------- Randomized traffic vs. model ----------------
    model_reset();
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      rst             = ($urandom_range(0, 299) == 0);
      bus.mem_ready   = ($urandom_range(0, 3) != 0);
      bus.mem_rdata   = ($urandom_range(0, 3) == 0) ? CB : 8'($urandom);
      bus.ctrl_last   = ($urandom_range(0, 2) == 0);
      bus.ctrl_mem    = 1'($urandom_range(0, 1));
      bus.ctrl_halt   = ($urandom_range(0, 7) == 0);
      bus.irq_pending = ($urandom_range(0, 3) == 0);
      bus.ime         = 1'($urandom_range(0, 1));
      #1;
      model_eval();
      check_all($sformatf("rnd%0d", n), e_req, e_inc, e_uop, e_addr, e_step,
                e_ack, e_halted, e_err);
      if (rst) model_reset();
      else     model_advance();
    end
    @(negedge clk);
    rst = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
